// File: rtl/i2c_master.sv
// Single-master I2C initiator: START, address+R/W, NBYTES data bytes, STOP.
// Define I2C_MASTER_CLOCK_STRETCH_EN to let a slave stretch SCL during Q2.
module i2c_master #(
  parameter logic [6:0] I2C_ADDR = 7'h2A,
  parameter int         NBYTES   = 3,
  parameter int         DIV      = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        scl_inout,
  inout  wire        sda_inout,
  input  logic       start_in,
  input  logic       rw_in,
  output logic       ready_out,
  output logic       busy_out,
  input  logic [7:0] tx_data_in,
  output logic       tx_load_out,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  output logic       done_out,
  output logic       nack_out
);

  localparam int BW = $clog2(NBYTES + 1);
  localparam int QW = $clog2(DIV);
  localparam logic [BW-1:0] LAST = BW'(NBYTES - 1);
  localparam logic [QW-1:0] QMAX = QW'(DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, AACK, TXD, TACK, RXD, RACK, STOP
  } state_t;

  state_t          state, state_n;
  logic [QW-1:0]   qcnt;
  logic [1:0]      q;
  logic [2:0]      bcnt;
  logic [BW-1:0]   byte_cnt;
  logic [7:0]      sr;
  logic            rw, ack;
  logic            sda_s1, sda_s2;
  logic            scl_low, sda_low;
  logic            hold, qend, bit_end, smp, last, bit_st;

  assign scl_inout = scl_low ? 1'b0 : 1'bz;
  assign sda_inout = sda_low ? 1'b0 : 1'bz;

  assign bit_st = state inside {ADDR, AACK, TXD, TACK, RXD, RACK};

`ifdef I2C_MASTER_CLOCK_STRETCH_EN
  logic scl_s1, scl_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl_inout;
      scl_s2 <= scl_s1;
    end
  end

  // Q2 does not advance until SCL is really seen high
  assign hold = bit_st && (q == 2'd2) && !scl_s2;
`else
  assign hold = 1'b0;
`endif

  assign qend      = !hold && (qcnt == QMAX);
  assign bit_end   = qend && (q == 2'd3);
  assign smp       = qend && (q == 2'd2);
  assign last      = (byte_cnt == LAST);
  assign ready_out = (state == IDLE) && !done_out;
  assign busy_out  = !ready_out;

  always_comb begin
    state_n     = state;
    tx_load_out = 1'b0;
    scl_low     = 1'b0;
    sda_low     = 1'b0;
    unique case (state)
      IDLE: if (start_in && ready_out) state_n = START;
      START: begin
        sda_low = q[1];
        if (bit_end) state_n = ADDR;
      end
      ADDR, TXD: begin
        scl_low = !q[1];
        sda_low = !sr[7];
        if (bit_end && bcnt == 3'd7)
          state_n = (state == ADDR) ? AACK : TACK;
      end
      AACK, TACK: begin
        scl_low = !q[1];
        if (bit_end) begin
          if (ack) begin
            state_n = STOP;
          end else if (state == AACK) begin
            state_n     = rw ? RXD : TXD;
            tx_load_out = !rw;
          end else if (last) begin
            state_n = STOP;
          end else begin
            state_n     = TXD;
            tx_load_out = 1'b1;
          end
        end
      end
      RXD: begin
        scl_low = !q[1];
        if (bit_end && bcnt == 3'd7) state_n = RACK;
      end
      RACK: begin
        scl_low = !q[1];
        sda_low = !last;
        if (bit_end) state_n = last ? STOP : RXD;
      end
      STOP: begin
        scl_low = !q[1];
        sda_low = (q != 2'd3);
        if (bit_end) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      qcnt         <= '0;
      q            <= '0;
      bcnt         <= '0;
      byte_cnt     <= '0;
      sr           <= '0;
      rw           <= 1'b0;
      ack          <= 1'b1;
      sda_s1       <= 1'b1;
      sda_s2       <= 1'b1;
      nack_out     <= 1'b0;
      rx_data_out  <= '0;
      rx_valid_out <= 1'b0;
      done_out     <= 1'b0;
    end else begin
      state        <= state_n;
      sda_s1       <= sda_inout;
      sda_s2       <= sda_s1;
      rx_valid_out <= 1'b0;
      done_out     <= 1'b0;
      if (state == IDLE) begin
        qcnt     <= '0;
        q        <= '0;
        bcnt     <= '0;
        byte_cnt <= '0;
      end else begin
        qcnt <= (hold || qend) ? '0 : qcnt + QW'(1);
        if (qend) q <= q + 2'd1;
        if (bit_end) bcnt <= (state_n == state) ? bcnt + 3'd1 : 3'd0;
      end
      if (state == IDLE && state_n == START) begin
        rw       <= rw_in;
        nack_out <= 1'b0;
      end
      if (state == IDLE && state_n == START)
        sr <= {I2C_ADDR, rw_in};
      else if (tx_load_out)
        sr <= tx_data_in;
      else if (bit_end && (state == ADDR || state == TXD))
        sr <= {sr[6:0], 1'b0};
      else if (smp && state == RXD)
        sr <= {sr[6:0], sda_s2};
      if (smp) ack <= sda_s2;
      if (smp && state == RXD && bcnt == 3'd7) begin
        rx_data_out  <= {sr[6:0], sda_s2};
        rx_valid_out <= 1'b1;
      end
      if (bit_end && (state == AACK || state == TACK) && ack)
        nack_out <= 1'b1;
      if (bit_end && !last &&
          ((state == TACK && !ack) || state == RACK))
        byte_cnt <= byte_cnt + BW'(1);
      if (state == STOP && bit_end) done_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Scoreboard bench for i2c_master: slave/bus model predicts bytes, ACKs,
// rx data, load counts and done/nack; monitors pop and compare.
module tb_i2c_master;

  localparam int NB   = 3;
  localparam int DV   = 4;
  localparam int CLKP = 10;
  localparam logic [6:0] ADR = 7'h2A;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_in;
  logic       rw_in;
  logic [7:0] tx_data_in;
  logic       ready_out, busy_out, tx_load_out;
  logic [7:0] rx_data_out;
  logic       rx_valid_out, done_out, nack_out;
  tri1        scl_w;
  tri1        sda_w;
  logic       sda_drv = 1'b0;

  assign sda_w = sda_drv ? 1'b0 : 1'bz;

  i2c_master #(.I2C_ADDR(ADR), .NBYTES(NB), .DIV(DV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl_inout    (scl_w),
    .sda_inout    (sda_w),
    .start_in     (start_in),
    .rw_in        (rw_in),
    .ready_out    (ready_out),
    .busy_out     (busy_out),
    .tx_data_in   (tx_data_in),
    .tx_load_out  (tx_load_out),
    .rx_data_out  (rx_data_out),
    .rx_valid_out (rx_valid_out),
    .done_out     (done_out),
    .nack_out     (nack_out)
  );

  always #(CLKP / 2) clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // expectations produced by the stimulus side
  logic [8:0] exp_bus[$];
  logic [7:0] exp_rx[$];
  logic       exp_done[$];
  int         exp_loads;
  int         starts_exp = 0;
  logic [7:0] fdata[NB];
  logic [7:0] txbuf[NB];
  logic [7:0] rd_data[NB];
  logic       slave_en = 1'b1;
  int         gen = 0;

  // write-data source and load counter
  int gen_seen = 0;
  int tx_idx = 0;
  int frame_loads = 0;
  bit pend = 0;
  always @(negedge clk) begin
    if (gen != gen_seen) begin
      gen_seen = gen;
      tx_idx = 0;
      frame_loads = 0;
      pend = 0;
    end
    if (pend) tx_idx++;
    pend = tx_load_out;
    if (tx_load_out) frame_loads++;
    tx_data_in = txbuf[tx_idx % NB];
  end

  // slave and bus monitor, sampled between clock edges
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       in_frame = 1'b0, rd_mode = 1'b0, slave_act = 1'b0;
  logic       rise_ok = 1'b0;
  logic [7:0] shreg = '0;
  int         s = 0, nbyte = 0, n_starts = 0;
  longint     last_rise = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      sda_drv = 1'b0;
    end else if (prev_scl && scl_w && prev_sda && !sda_w) begin
      in_frame = 1'b1;
      slave_act = 1'b1;
      rise_ok = 1'b0;
      s = 0;
      nbyte = 0;
      n_starts++;
      sda_drv = 1'b0;
    end else if (prev_scl && scl_w && !prev_sda && sda_w) begin
      in_frame = 1'b0;
      sda_drv = 1'b0;
    end else if (in_frame && !prev_scl && scl_w) begin
      if (rise_ok)
        chk("scl_period", 32'($time - last_rise), 4 * DV * CLKP);
      rise_ok = 1'b1;
      last_rise = $time;
      if (s < 8) begin
        shreg = {shreg[6:0], sda_w};
        if (s == 7 && nbyte == 0) rd_mode = sda_w;
      end else begin
        if (exp_bus.size() == 0) begin
          chk("bus_unexpected", {23'd0, shreg, sda_w}, 32'h1ff);
        end else begin
          chk("bus_byte_ack", {23'd0, shreg, sda_w},
              {23'd0, exp_bus.pop_front()});
        end
        if (rd_mode && nbyte > 0 && sda_w) slave_act = 1'b0;
        nbyte++;
      end
      s = (s == 8) ? 0 : s + 1;
    end else if (in_frame && prev_scl && !scl_w) begin
      sda_drv = 1'b0;
      if (slave_en && slave_act) begin
        if (s == 8)
          sda_drv = (nbyte == 0) || !rd_mode;
        else if (rd_mode && nbyte > 0 && nbyte <= NB)
          sda_drv = !rd_data[nbyte-1][7-s];
      end
    end
    prev_scl = scl_w;
    prev_sda = sda_w;
  end

  // rx scoreboard
  always @(negedge clk) begin
    if (rst_n && rx_valid_out) begin
      if (exp_rx.size() == 0)
        chk("rx_unexpected", {24'd0, rx_data_out}, 32'hffff);
      else
        chk("rx_data", {24'd0, rx_data_out}, {24'd0, exp_rx.pop_front()});
    end
  end

  // done scoreboard
  int n_done = 0;
  always @(negedge clk) begin
    if (rst_n && done_out) begin
      n_done++;
      chk("done_ready_low", {31'd0, ready_out}, 0);
      chk("tx_load_count", frame_loads, exp_loads);
      chk("rx_left", exp_rx.size(), 0);
      chk("bus_left", exp_bus.size(), 0);
      if (exp_done.size() == 0)
        chk("done_unexpected", 1, 0);
      else
        chk("nack_flag", {31'd0, nack_out}, {31'd0, exp_done.pop_front()});
    end
  end

  task automatic prepare(input logic rw, input logic sen);
    logic [8:0] v;
    slave_en = sen;
    for (int i = 0; i < NB; i++) begin
      txbuf[i] = fdata[i];
      rd_data[i] = fdata[i];
    end
    gen++;
    v = {ADR, rw, !sen};
    exp_bus.push_back(v);
    if (sen) begin
      for (int i = 0; i < NB; i++) begin
        v = {fdata[i], rw ? (i == NB - 1) : 1'b0};
        exp_bus.push_back(v);
        if (rw) exp_rx.push_back(fdata[i]);
      end
    end
    exp_done.push_back(!sen);
    exp_loads = (!rw && sen) ? NB : 0;
    starts_exp++;
  endtask

  task automatic start_frame(input logic rw);
    int t = 0;
    while (!ready_out && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("ready_timeout", 1, 0);
    @(negedge clk);
    start_in = 1'b1;
    rw_in = rw;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    int d0 = n_done;
    while (n_done == d0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("done_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic frame(input logic rw, input logic sen);
    prepare(rw, sen);
    start_frame(rw);
    wait_done();
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    start_in = 1'b0;
    rw_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready_out}, 1);
    chk("rst_busy", {31'd0, busy_out}, 0);
    chk("rst_nack", {31'd0, nack_out}, 0);
    chk("rst_rx_data", {24'd0, rx_data_out}, 0);
    chk("rst_pulses", {29'd0, tx_load_out, rx_valid_out, done_out}, 0);
    chk("rst_lines", {30'd0, scl_w, sda_w}, 3);
    rst_n = 1'b1;
    @(negedge clk);

    fdata = '{8'h11, 8'h22, 8'h33};
    frame(1'b0, 1'b1);

    fdata = '{8'hC3, 8'h3C, 8'h99};
    frame(1'b0, 1'b0);

    fdata = '{8'hA5, 8'h5A, 8'hFF};
    frame(1'b1, 1'b1);

    // reset during bit 3 of the first data byte
    fdata = '{8'h0F, 8'hF0, 8'h81};
    prepare(1'b0, 1'b1);
    start_frame(1'b0);
    t = 0;
    while (!tx_load_out && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("load_timeout", 1, 0);
    repeat (3 * 4 * DV + 6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_lines", {30'd0, scl_w, sda_w}, 3);
    chk("midrst_ready", {31'd0, ready_out}, 1);
    chk("midrst_busy", {31'd0, busy_out}, 0);
    exp_bus.delete();
    exp_rx.delete();
    exp_done.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fdata = '{8'h12, 8'h34, 8'h56};
    frame(1'b0, 1'b1);

    // start requests while busy and in the done cycle
    fdata = '{8'h6E, 8'hB1, 8'h07};
    prepare(1'b1, 1'b1);
    start_frame(1'b1);
    repeat (150) @(negedge clk);
    start_in = 1'b1;
    rw_in = 1'b0;
    @(negedge clk);
    start_in = 1'b0;
    t = 0;
    while (!done_out && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("done_wait_timeout", 1, 0);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (40) @(negedge clk);
    chk("ignored_starts", n_starts, starts_exp);
    chk("idle_after_ignore", {30'd0, ready_out, busy_out}, 2);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NB; i++) fdata[i] = 8'($urandom);
      frame(1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
    end
    chk("total_starts", n_starts, starts_exp);
    chk("sb_empty", exp_bus.size() + exp_rx.size() + exp_done.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
